// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, mask constants and result bundle type for the FPU result collector
package fpu_pkg;
  localparam int RES_W = 32;
  localparam int RES_TAG_W = 4;
  localparam int RES_DEPTH = 4;
  localparam logic [2:0] MASK_ALL = 3'b111;
  localparam logic [2:0] MASK_SUB = 3'b100;
  typedef struct packed {
    logic [RES_W-1:0] add;
    logic [RES_W-1:0] mul;
    logic [RES_W-1:0] sub;
    logic [2:0] mask;
    logic [RES_TAG_W-1:0] tag;
  } res_bundle_t;
endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: first-word-fall-through FIFO of DEPTH x BW-bit entries
// Ports: push_i/din_i write (dropped when full unless popping), pop_i reads head (ignored when empty),
//        dout_o head entry, full_o/empty_o status, count_o occupancy.
module fpu_res_fifo #(
  parameter int BW = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [BW-1:0] din_i,
  output logic [BW-1:0] dout_o,
  output logic full_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [BW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr_en, rd_en;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign rd_en = pop_i & ~empty_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en = push_i & (~full_o | rd_en);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr_en);
      rd_q <= rd_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/fpu_res_collect.sv
// fpu_res_collect: captures add/mul/sub results on controller strobe events and queues tagged bundles
// Ports: en + add_vld/mul_vld/sub_vld/fi strobes from the timing controller, add_res/mul_res/sub_res data,
//        out_* valid/ready head bundle, stall (queue full), count, sticky overflow with clr_ovf.
module fpu_res_collect
  import fpu_pkg::*;
#(
  parameter int W = RES_W,
  parameter int DEPTH = RES_DEPTH,
  parameter int TAG_W = RES_TAG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic add_vld,
  input  logic mul_vld,
  input  logic sub_vld,
  input  logic fi,
  input  logic [W-1:0] add_res,
  input  logic [W-1:0] mul_res,
  input  logic [W-1:0] sub_res,
  output logic out_valid,
  input  logic out_ready,
  output logic [W-1:0] out_add,
  output logic [W-1:0] out_mul,
  output logic [W-1:0] out_sub,
  output logic [2:0] out_mask,
  output logic [TAG_W-1:0] out_tag,
  output logic stall,
  output logic [$clog2(DEPTH):0] count,
  output logic overflow,
  input  logic clr_ovf
);
  localparam int BW = 3*W + 3 + TAG_W;
  logic en_q, overflow_q, overflow_d;
  logic [W-1:0] add_q, add_d, mul_q, mul_d;
  logic [2:0] mask_q, mask_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic add_evt, mul_evt, sub_evt, fi_evt, full, empty, pop, drop;
  logic [BW-1:0] push_data, head;
  // strobes are levels held while en is low; only the first cycle after an advance is an event
  always_comb begin
    add_evt = add_vld & en_q;
    mul_evt = mul_vld & en_q;
    sub_evt = sub_vld & en_q;
    fi_evt = fi & en_q;
    pop = ~empty & out_ready;
    drop = fi_evt & full & ~pop;
    add_d = add_evt ? add_res : add_q;
    mul_d = mul_evt ? mul_res : mul_q;
    mask_d = fi_evt ? 3'b000 : mask_q | {1'b0, mul_evt, add_evt};
    tag_d = tag_q + TAG_W'(fi_evt);
    overflow_d = drop | (overflow_q & ~clr_ovf);
    push_data = {add_q, mul_q, sub_res, mask_q | ((fi_evt | sub_evt) ? MASK_SUB : 3'b000), tag_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
      add_q <= '0;
      mul_q <= '0;
      mask_q <= '0;
      tag_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      en_q <= en;
      add_q <= add_d;
      mul_q <= mul_d;
      mask_q <= mask_d;
      tag_q <= tag_d;
      overflow_q <= overflow_d;
    end
  end
  fpu_res_fifo #(.BW(BW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(fi_evt),
    .pop_i(out_ready),
    .din_i(push_data),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign out_valid = ~empty;
  assign stall = full;
  assign overflow = overflow_q;
  assign {out_add, out_mul, out_sub, out_mask, out_tag} = head;
endmodule

// File: tb/tb_fpu_res_collect.sv
// tb_fpu_res_collect: directed self-checking bench driving a model of the timing controller
module tb_fpu_res_collect;
  import fpu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic add_vld, mul_vld, sub_vld, fi, out_valid, stall, overflow;
  logic [31:0] add_res = '0, mul_res = '0, sub_res = '0, out_add, out_mul, out_sub;
  logic [2:0] out_mask;
  logic [3:0] out_tag;
  logic [2:0] count;
  logic [1:0] cnt;
  int checks = 0, errors = 0;

  fpu_res_collect #(.W(32), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .add_vld(add_vld), .mul_vld(mul_vld), .sub_vld(sub_vld), .fi(fi),
    .add_res(add_res), .mul_res(mul_res), .sub_res(sub_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_add(out_add), .out_mul(out_mul), .out_sub(out_sub), .out_mask(out_mask), .out_tag(out_tag),
    .stall(stall), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 2'd0;
    else if (en) cnt <= cnt + 2'd1;
  end
  assign add_vld = cnt == 2'd1;
  assign mul_vld = cnt == 2'd2;
  assign sub_vld = cnt == 2'd3;
  assign fi = cnt == 2'd3;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  // one controller sequence: four en steps, each followed by gap idle cycles
  task automatic run_seq(input logic [31:0] a, input logic [31:0] m, input logic [31:0] s,
                         input int gap, input bit pop_last, input bit clr_last);
    add_res = a; mul_res = m; sub_res = s;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      if (i == 3 && pop_last) out_ready = 1'b1;
      if (i == 3 && clr_last) clr_ovf = 1'b1;
      tick;
      en = 1'b0;
      if (i == 3 && pop_last) out_ready = 1'b0;
      if (i == 3 && clr_last) clr_ovf = 1'b0;
      repeat (gap) tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_continuous;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_seq(32'h3F800000 + i, 32'h40000000 + i, 32'h40400000 + i, 0, 0, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cont_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL cont_tag[%0d] got %0d want %0d", i, out_tag, i); end
      checks++; if (out_mask !== MASK_ALL) begin errors++; $display("FAIL cont_mask[%0d] got %b want 111", i, out_mask); end
      checks++; if (out_add !== 32'h3F800000 + i) begin errors++; $display("FAIL cont_add[%0d] got %h want %h", i, out_add, 32'h3F800000 + i); end
      checks++; if (out_mul !== 32'h40000000 + i) begin errors++; $display("FAIL cont_mul[%0d] got %h want %h", i, out_mul, 32'h40000000 + i); end
      checks++; if (out_sub !== 32'h40400000 + i) begin errors++; $display("FAIL cont_sub[%0d] got %h want %h", i, out_sub, 32'h40400000 + i); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL cont_count[%0d] got %0d want 1", i, count); end
    end
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cont_drained got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL cont_count_end got %0d want 0", count); end
  endtask

  task automatic test_gapped;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_seq(32'h11110000 + i, 32'h22220000 + i, 32'h33330000 + i, 3, 0, 0);
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL gap_count[%0d] got %0d want %0d", i, count, i + 1); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_tag !== 4'(3 + i)) begin errors++; $display("FAIL gap_tag[%0d] got %0d want %0d", i, out_tag, 3 + i); end
      checks++; if (out_mask !== MASK_ALL) begin errors++; $display("FAIL gap_mask[%0d] got %b want 111", i, out_mask); end
      checks++; if (out_add !== 32'h11110000 + i) begin errors++; $display("FAIL gap_add[%0d] got %h want %h", i, out_add, 32'h11110000 + i); end
      checks++; if (out_mul !== 32'h22220000 + i) begin errors++; $display("FAIL gap_mul[%0d] got %h want %h", i, out_mul, 32'h22220000 + i); end
      checks++; if (out_sub !== 32'h33330000 + i) begin errors++; $display("FAIL gap_sub[%0d] got %h want %h", i, out_sub, 32'h33330000 + i); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL gap_count_end got %0d want 0", count); end
  endtask

  task automatic test_overflow;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      run_seq(32'h1, 32'h2, 32'hA0 + i, 0, 0, 0);
      if (i == 3) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovf_stall got %b want 1", stall); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count4 got %0d want 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_hold got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL ovf_tag[%0d] got %0d want %0d", i, out_tag, i); end
      checks++; if (out_sub !== 32'hA0 + i) begin errors++; $display("FAIL ovf_sub[%0d] got %h want %h", i, out_sub, 32'hA0 + i); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ovf_stall_end got %b want 0", stall); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    run_seq(32'h1, 32'h2, 32'hA5, 0, 0, 0);
    checks++; if (out_tag !== 4'd5) begin errors++; $display("FAIL ovf_next_tag got %0d want 5", out_tag); end
    checks++; if (out_sub !== 32'hA5) begin errors++; $display("FAIL ovf_next_sub got %h want a5", out_sub); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop;
    do_reset;
    for (int i = 0; i < 4; i++) run_seq(32'h5, 32'h6, 32'hB0 + i, 0, 0, 0);
    run_seq(32'h5, 32'h6, 32'hB4, 0, 1, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fp_count got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf got %b want 0", overflow); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fp_stall got %b want 1", stall); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL fp_tag[%0d] got %0d want %0d", i, out_tag, i); end
      checks++; if (out_sub !== 32'hB0 + i) begin errors++; $display("FAIL fp_sub[%0d] got %h want %h", i, out_sub, 32'hB0 + i); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    for (int i = 0; i < 2; i++) run_seq(32'h7, 32'h8, 32'hC0 + i, 0, 0, 0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL mr_count_pre got %0d want 2", count); end
    add_res = 32'h9;
    en = 1'b1;
    tick;
    tick;
    en = 1'b0;
    checks++; if (dut.mask_q !== 3'b001) begin errors++; $display("FAIL mr_mask_pre got %b want 001", dut.mask_q); end
    rst = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mr_count got %0d want 0", count); end
    checks++; if (dut.tag_q !== 4'd0) begin errors++; $display("FAIL mr_tag got %0d want 0", dut.tag_q); end
    checks++; if (dut.mask_q !== 3'b000) begin errors++; $display("FAIL mr_mask got %b want 000", dut.mask_q); end
    rst = 1'b0;
    run_seq(32'h7, 32'h8, 32'hC9, 0, 0, 0);
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL mr_tag_after got %0d want 0", out_tag); end
    checks++; if (out_sub !== 32'hC9) begin errors++; $display("FAIL mr_sub_after got %h want c9", out_sub); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL mr_count_after got %0d want 1", count); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_seq(32'hD, 32'hE, 32'hD00 + i, 0, 0, 0);
      checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL wrap_tag[%0d] got %0d want %0d", i, out_tag, i % 16); end
    end
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) run_seq(32'hD, 32'hE, 32'hE00 + i, 0, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b want 1", overflow); end
    run_seq(32'hD, 32'hE, 32'hE05, 0, 0, 1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_set_wins got %b want 1", overflow); end
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_clr got %b want 0", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", count); end
  endtask

  initial begin
    test_reset;
    test_continuous;
    test_gapped;
    test_overflow;
    test_full_pop;
    test_mid_reset;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
